// File: rtl/exe_stage_mc.sv
// MIPS execute stage: operand forwarding, single-cycle ALU and a shift-add
// multiplier, with the result held in a valid/ready output register.
module exe_stage_mc #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       exe_cmd,
    input  logic [WIDTH-1:0] val1,
    input  logic [WIDTH-1:0] val2,
    input  logic [WIDTH-1:0] mem_alu_result,
    input  logic [WIDTH-1:0] wb_result_wb,
    input  logic [1:0]       src1_decider,
    input  logic [1:0]       src2_decider,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_result,
    output logic             zero,
    output logic             busy
);
    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] CMD_ADD = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0001;
    localparam logic [3:0] CMD_AND = 4'b0010;
    localparam logic [3:0] CMD_OR  = 4'b0011;
    localparam logic [3:0] CMD_NOR = 4'b0100;
    localparam logic [3:0] CMD_XOR = 4'b0101;
    localparam logic [3:0] CMD_SLL = 4'b0110;
    localparam logic [3:0] CMD_SRL = 4'b0111;
    localparam logic [3:0] CMD_SRA = 4'b1000;
    localparam logic [3:0] CMD_SLT = 4'b1001;
    localparam logic [3:0] CMD_MUL = 4'b1100;

    typedef enum logic {IDLE, MUL_BUSY} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             zero_q, zero_d;
    logic             out_valid_q, out_valid_d;

    logic [WIDTH-1:0] src1, src2, alu_comb, acc_next;
    logic [SHW-1:0]   shamt;
    logic             accept;

    function automatic logic [WIDTH-1:0] fwd_sel(input logic [1:0] dec,
                                                 input logic [WIDTH-1:0] rf,
                                                 input logic [WIDTH-1:0] mem,
                                                 input logic [WIDTH-1:0] wb);
        case (dec)
            2'd0:    return rf;
            2'd1:    return mem;
            2'd2:    return wb;
            default: return '0;
        endcase
    endfunction

    assign src1  = fwd_sel(src1_decider, val1, mem_alu_result, wb_result_wb);
    assign src2  = fwd_sel(src2_decider, val2, mem_alu_result, wb_result_wb);
    assign shamt = src2[SHW-1:0];

    always_comb begin
        alu_comb = '0;
        case (exe_cmd)
            CMD_ADD: alu_comb = src1 + src2;
            CMD_SUB: alu_comb = src1 - src2;
            CMD_AND: alu_comb = src1 & src2;
            CMD_OR:  alu_comb = src1 | src2;
            CMD_NOR: alu_comb = ~(src1 | src2);
            CMD_XOR: alu_comb = src1 ^ src2;
            CMD_SLL: alu_comb = src1 << shamt;
            CMD_SRL: alu_comb = src1 >> shamt;
            CMD_SRA: alu_comb = $unsigned($signed(src1) >>> shamt);
            CMD_SLT: alu_comb = {{(WIDTH-1){1'b0}}, $signed(src1) < $signed(src2)};
            default: alu_comb = '0;
        endcase
    end

    // A held result blocks acceptance unless it is being retired this same edge.
    assign in_ready = (state_q == IDLE) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready && !flush;
    assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_comb begin
        state_d     = state_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        res_d       = res_q;
        zero_d      = zero_q;
        out_valid_d = out_valid_q;
        if (flush) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            cnt_d       = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (exe_cmd == CMD_MUL) begin
                            state_d     = MUL_BUSY;
                            mcand_d     = src1;
                            mplier_d    = src2;
                            acc_d       = '0;
                            cnt_d       = '0;
                            out_valid_d = 1'b0;
                        end else begin
                            res_d       = alu_comb;
                            zero_d      = (alu_comb == '0);
                            out_valid_d = 1'b1;
                        end
                    end else if (out_valid_q && out_ready) begin
                        out_valid_d = 1'b0;
                    end
                end
                MUL_BUSY: begin
                    acc_d    = acc_next;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + SHW'(1);
                    // Last bit folds into the result directly, so it lands WIDTH cycles after accept.
                    if (cnt_q == SHW'(WIDTH-1)) begin
                        res_d       = acc_next;
                        zero_d      = (acc_next == '0);
                        out_valid_d = 1'b1;
                        state_d     = IDLE;
                        cnt_d       = '0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            res_q       <= '0;
            zero_q      <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            res_q       <= res_d;
            zero_q      <= zero_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign alu_result = res_q;
    assign zero       = zero_q;
    assign busy       = (state_q == MUL_BUSY);

endmodule

// File: doc/exe_stage_mc.md
Name: exe_stage_mc

Overview:
Parametrised execute stage for the MIPS pipeline. Resolves forwarding for both operands, runs single-cycle ALU operations, and runs an iterative multi-cycle multiply. The result is held in an output register under a valid/ready handshake, so the hazard unit can stall ID/EXE while a multiply is in flight. It sits between the ID/EXE and EXE/MEM pipeline registers.

Parameters:
WIDTH, 32, datapath width in bits; must be a power of two and at least 8.
SHW, $clog2(WIDTH), derived shift-amount width; not overridden.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst_n  in  1  asynchronous active-low reset.
flush  in  1  synchronous pipeline flush.
in_valid  in  1  an operation is presented.
in_ready  out  1  the stage can accept an operation this cycle.
exe_cmd  in  4  operation code.
val1  in  WIDTH  operand 1 from the register file.
val2  in  WIDTH  operand 2 from the register file or immediate.
mem_alu_result  in  WIDTH  forwarded value from the MEM stage.
wb_result_wb  in  WIDTH  forwarded value from the WB stage.
src1_decider  in  2  operand-1 select: 0 val1, 1 mem_alu_result, 2 wb_result_wb, 3 zero.
src2_decider  in  2  operand-2 select, same encoding.
out_valid  out  1  alu_result holds a completed result.
out_ready  in  1  downstream consumes the result.
alu_result  out  WIDTH  registered result.
zero  out  1  registered flag: alu_result == 0.
busy  out  1  high while a multiply is iterating.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; out_valid 0; alu_result 0; zero 1; busy 0; iteration counter 0.
- Forwarding muxes are combinational. Operands are sampled only on the accepting edge.
- in_ready = (state==IDLE) && (!out_valid || out_ready). The operation is accepted on an edge where in_valid && in_ready.
- exe_cmd encoding:
  - 0000 ADD, 0001 SUB (both wrap modulo 2^WIDTH, no overflow trap).
  - 0010 AND, 0011 OR, 0100 NOR, 0101 XOR.
  - 0110 SLL, 0111 SRL, 1000 SRA, 1001 SLT (signed, result 0 or 1).
  - 1100 MUL: low WIDTH bits of the unsigned product.
  - Any other code gives result 0.
  - Shift amount is src2[SHW-1:0]; the shifted operand is src1.
- ALU ops: the result is registered on the accepting edge; out_valid is high the following cycle (latency 1).
- MUL, state machine IDLE -> MUL_BUSY -> IDLE:
  - On accept: load multiplicand, multiplier and accumulator 0; counter = 0; busy = 1.
  - Each MUL_BUSY cycle processes one multiplier bit (shift-add) and increments the counter.
  - On the edge where counter reaches WIDTH-1, write alu_result, set out_valid, clear busy, and return to IDLE.
  - The result is visible WIDTH cycles after the accepting edge.
  - in_ready is 0 throughout MUL_BUSY.
- Output hold: while out_valid && !out_ready, alu_result and zero are stable and no new operation is accepted.
- out_valid && out_ready && in_valid in the same cycle: the old result is retired and the new operation is accepted on the same edge. There is no bubble for back-to-back ALU ops.
- out_ready with out_valid and no new accept: out_valid drops the next cycle; alu_result keeps its last value.
- flush (priority over all other events except reset):
  - Next edge: out_valid 0, any multiply is aborted, busy 0, state IDLE.
  - An in_valid presented in the flush cycle is discarded.
  - alu_result is not cleared.
- Reset mid-multiply: immediate return to the reset values; no partial result is emitted.
- zero is always updated together with alu_result.

Test Plan:
- Reset, then ADD val1=5, val2=7, deciders 0/0, out_ready=1 -> out_valid the next cycle, alu_result=12, zero=0.
- Forwarding: src1_decider=1 (mem=0xFFFFFFFF), src2_decider=2 (wb=1), SUB -> alu_result=0xFFFFFFFE. Same setup with src1_decider=3, ADD -> alu_result=1.
- Shifts: SRA src1=0x80000000, src2=0x24 (shift 4) -> 0xF8000000. SLT 0xFFFFFFFF vs 1 -> 1.
- MUL 0x10001 x 0x10001 -> busy and in_ready=0 for 32 cycles, then out_valid with alu_result=0x00020001. An in_valid held during the busy window is accepted only after completion.
- Backpressure: out_ready=0 after an ADD result -> alu_result stable and in_ready=0 for 5 cycles. Raise out_ready together with a pending XOR -> the XOR result appears the next cycle with no gap.
- flush on multiply cycle 10 -> busy=0 and out_valid never rises for that MUL. Separately, assert rst_n=0 mid-multiply -> all outputs return to reset values immediately.
